// File: rtl/dbg_uart_pkg.sv
// Shared types and frame constants for the UART debug bridge.
package dbg_uart_pkg;
  typedef enum logic [1:0] {COLLECT, WAIT, RESP} state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  localparam int FRAME_LEN = 9;
  localparam int RESP_LEN  = 5;

  localparam logic [7:0] STATUS_OK      = 8'h00;
  localparam logic [7:0] STATUS_TIMEOUT = 8'hFF;
  localparam logic [7:0] CMD_NOP        = 8'h00;
endpackage

// File: rtl/dbg_uart_phy.sv
// 8N1 UART byte engine: synchronized RX deserializer and TX serializer.
module dbg_uart_phy import dbg_uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rstn_i,
  input  logic       rx_line,
  output logic       tx_line,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_frame_err,
  input  logic [7:0] tx_byte,
  input  logic       tx_start,
  output logic       tx_busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]    sync;
  logic          rx_s, rx_prev;
  rx_state_t     rx_st;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;

  assign rx_s    = sync[1];
  assign rx_byte = rx_sh;

  always_ff @(posedge clk) begin
    if (!rstn_i) begin
      sync         <= 2'b11;
      rx_prev      <= 1'b1;
      rx_st        <= RX_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_sh        <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      sync         <= {sync[0], rx_line};
      rx_prev      <= rx_s;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_cnt       <= rx_cnt + 1'b1;
      case (rx_st)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (rx_prev && !rx_s) rx_st <= RX_START;
        end
        // a start bit that has gone high again by mid-bit is treated as a glitch
        RX_START: if (rx_cnt == BIT_HALF) begin
          rx_cnt <= '0;
          rx_bit <= '0;
          rx_st  <= rx_s ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (rx_cnt == BIT_LAST) begin
          rx_cnt <= '0;
          rx_sh  <= {rx_s, rx_sh[7:1]};
          rx_bit <= rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_st <= RX_STOP;
        end
        RX_STOP: if (rx_cnt == BIT_LAST) begin
          rx_st        <= RX_IDLE;
          rx_valid     <= rx_s;
          rx_frame_err <= !rx_s;
        end
        default: rx_st <= RX_IDLE;
      endcase
    end
  end

  logic          tx_act, tx_last;
  logic [9:0]    tx_sh;
  logic [3:0]    tx_bit;
  logic [CW-1:0] tx_cnt;

  // busy drops in the final stop-bit cycle so the next byte follows with no gap
  assign tx_last = tx_act && (tx_bit == 4'd9) && (tx_cnt == BIT_LAST);
  assign tx_busy = tx_act && !tx_last;
  assign tx_line = tx_act ? tx_sh[0] : 1'b1;

  always_ff @(posedge clk) begin
    if (!rstn_i) begin
      tx_act <= 1'b0;
      tx_sh  <= '1;
      tx_bit <= '0;
      tx_cnt <= '0;
    end else if (tx_start && !tx_busy) begin
      tx_act <= 1'b1;
      tx_sh  <= {1'b1, tx_byte, 1'b0};
      tx_bit <= '0;
      tx_cnt <= '0;
    end else if (tx_act) begin
      if (tx_cnt == BIT_LAST) begin
        tx_cnt <= '0;
        tx_bit <= tx_bit + 4'd1;
        tx_sh  <= {1'b1, tx_sh[9:1]};
        if (tx_last) tx_act <= 1'b0;
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/dbg_uart_bridge.sv
// UART command-frame front end: collects 9-byte frames, drives the debug port,
// and answers with a 5-byte status/read-data frame.
module dbg_uart_bridge import dbg_uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 434,
  parameter int GAP_CYC      = 65536,
  parameter int TIMEOUT_CYC  = 4096
) (
  input  logic        clk,
  input  logic        rstn_i,
  input  logic        uart_rx_i,
  output logic        uart_tx_o,
  output logic [7:0]  dbg_cmd_o,
  output logic [31:0] dbg_addr_o,
  output logic [31:0] dbg_data_o,
  input  logic [31:0] dbg_data_i,
  input  logic        dbg_ready_i
);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GW-1:0] GAP_LIM = GW'(GAP_CYC);
  localparam logic [TW-1:0] TO_LIM  = TW'(TIMEOUT_CYC - 1);

  logic [7:0]              rx_byte;
  logic                    rx_valid, rx_frame_err, tx_start, tx_busy;
  state_t                  state, state_nx;
  logic [3:0]              idx;
  logic [FRAME_LEN-2:0][7:0] fbuf;
  logic [GW-1:0]           gap_cnt;
  logic [TW-1:0]           wait_cnt;
  logic [2:0]              tx_idx;
  logic [RESP_LEN*8-1:0]   resp_sh;
  logic                    frame_done;

  dbg_uart_phy #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_phy (
    .clk(clk), .rstn_i(rstn_i), .rx_line(uart_rx_i), .tx_line(uart_tx_o),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err),
    .tx_byte(resp_sh[RESP_LEN*8-1 -: 8]), .tx_start(tx_start), .tx_busy(tx_busy)
  );

  assign frame_done = rx_valid && (idx == 4'(FRAME_LEN - 1));

  always_ff @(posedge clk) begin
    if (!rstn_i) state <= COLLECT;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tx_start = 1'b0;
    case (state)
      COLLECT: if (state == COLLECT && frame_done && fbuf[0] != CMD_NOP) state_nx = WAIT;
      WAIT:    if (dbg_ready_i || wait_cnt >= TO_LIM) state_nx = RESP;
      RESP:    if (!tx_busy) begin
        if (tx_idx == 3'(RESP_LEN)) state_nx = COLLECT;
        else                        tx_start = 1'b1;
      end
      default: state_nx = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn_i) begin
      idx        <= '0;
      fbuf       <= '0;
      gap_cnt    <= '0;
      wait_cnt   <= '0;
      tx_idx     <= '0;
      resp_sh    <= '0;
      dbg_cmd_o  <= CMD_NOP;
      dbg_addr_o <= '0;
      dbg_data_o <= '0;
    end else begin
      if (rx_valid || rx_frame_err) gap_cnt <= '0;
      else if (gap_cnt < GAP_LIM)   gap_cnt <= gap_cnt + 1'b1;
      case (state)
        COLLECT: begin
          wait_cnt <= '0;
          if (rx_frame_err) begin
            idx <= '0;
          end else if (rx_valid) begin
            if (frame_done) begin
              idx <= '0;
              // last byte goes straight to the port; a NOP frame is simply dropped
              if (fbuf[0] != CMD_NOP) begin
                dbg_cmd_o  <= fbuf[0];
                dbg_addr_o <= {fbuf[1], fbuf[2], fbuf[3], fbuf[4]};
                dbg_data_o <= {fbuf[5], fbuf[6], fbuf[7], rx_byte};
              end
            end else begin
              fbuf[idx[2:0]] <= rx_byte;
              idx            <= idx + 4'd1;
            end
          end else if (idx != '0 && gap_cnt >= GAP_LIM) begin
            idx <= '0;
          end
        end
        WAIT: begin
          tx_idx <= '0;
          if (wait_cnt < TO_LIM) wait_cnt <= wait_cnt + 1'b1;
          if (dbg_ready_i) begin
            dbg_cmd_o <= CMD_NOP;
            resp_sh   <= {STATUS_OK, dbg_data_i};
          end else if (wait_cnt >= TO_LIM) begin
            dbg_cmd_o <= CMD_NOP;
            resp_sh   <= {STATUS_TIMEOUT, 32'h0};
          end
        end
        RESP: if (tx_start) begin
          resp_sh <= resp_sh << 8;
          tx_idx  <= tx_idx + 3'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dbg_uart_bridge.sv
// Directed bench for dbg_uart_bridge: UART host driver, debug-port model, TX byte monitor.
module tb_dbg_uart_bridge;
  localparam int CPB = 8;
  localparam int GAP = 200;
  localparam int TO  = 64;

  logic        clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic        uart_rx_i = 1'b1;
  logic        uart_tx_o;
  logic [7:0]  dbg_cmd_o;
  logic [31:0] dbg_addr_o, dbg_data_o;
  logic [31:0] dbg_data_i = 32'hCAFEF00D;
  logic        dbg_ready_i = 1'b0;

  int nvec = 0;
  int nerr = 0;

  dbg_uart_bridge #(.CLKS_PER_BIT(CPB), .GAP_CYC(GAP), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rstn_i(rstn_i), .uart_rx_i(uart_rx_i), .uart_tx_o(uart_tx_o),
    .dbg_cmd_o(dbg_cmd_o), .dbg_addr_o(dbg_addr_o), .dbg_data_o(dbg_data_o),
    .dbg_data_i(dbg_data_i), .dbg_ready_i(dbg_ready_i)
  );

  always #5 clk = ~clk;

  // debug-port model: counts commands, raises ready on the 5th live cycle
  logic        ready_en = 1'b1;
  int          ncmd = 0;
  int          live_cyc = 0;
  logic [7:0]  cap_cmd = 8'h00;
  logic [31:0] cap_addr = 32'h0, cap_data = 32'h0;
  logic [7:0]  cmd_after_rdy = 8'hAA;
  logic        rdy_prev = 1'b0, cmd_prev = 1'b0;

  always @(negedge clk) begin
    if (rdy_prev) cmd_after_rdy = dbg_cmd_o;
    if (dbg_cmd_o != 8'h00) begin
      if (!cmd_prev) begin
        ncmd++;
        cap_cmd  = dbg_cmd_o;
        cap_addr = dbg_addr_o;
        cap_data = dbg_data_o;
        live_cyc = 0;
      end
      live_cyc++;
      dbg_ready_i = ready_en && (live_cyc == 5);
    end else begin
      dbg_ready_i = 1'b0;
    end
    rdy_prev = dbg_ready_i;
    cmd_prev = (dbg_cmd_o != 8'h00);
  end

  // TX monitor samples mid-bit, which falls on a falling clock edge
  logic [7:0] tx_q[$];
  logic [7:0] mon_b;
  always begin
    @(negedge uart_tx_o);
    #(CPB * 5 + 5);
    if (uart_tx_o == 1'b0) begin
      for (int i = 0; i < 8; i++) begin
        #(CPB * 10);
        mon_b[i] = uart_tx_o;
      end
      #(CPB * 10);
      if (uart_tx_o) tx_q.push_back(mon_b);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    uart_rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx_i = stop;
    repeat (CPB) @(negedge clk);
    uart_rx_i = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d);
    logic [71:0] f;
    f = {c, a, d};
    for (int i = 8; i >= 0; i--) send_byte(f[i*8 +: 8], 1'b1);
  endtask

  task automatic wait_resp(input string tag, input logic [39:0] exp);
    int n;
    n = 0;
    while (tx_q.size() < 5 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (2 * CPB) @(negedge clk);
    check({tag, "_txcount"}, tx_q.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("%s_tx%0d", tag, i),
            (tx_q.size() > i) ? {56'h0, tx_q[i]} : 64'hDEAD,
            {56'h0, exp[39 - i*8 -: 8]});
    tx_q.delete();
  endtask

  initial begin
    int n;
    logic low_seen, cmd_seen;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_tx", uart_tx_o, 1);
    check("rst_cmd", dbg_cmd_o, 8'h00);
    check("rst_addr", dbg_addr_o, 32'h0);
    check("rst_data", dbg_data_o, 32'h0);
    rstn_i = 1'b1;
    repeat (4) @(negedge clk);

    // Test 1: normal command with ready
    cmd_after_rdy = 8'hAA;
    send_frame(8'h02, 32'h10000004, 32'hDEADBEEF);
    wait_resp("t1", 40'h00CAFEF00D);
    check("t1_ncmd", ncmd, 1);
    check("t1_cmd", cap_cmd, 8'h02);
    check("t1_addr", cap_addr, 32'h10000004);
    check("t1_data", cap_data, 32'hDEADBEEF);
    check("t1_live", live_cyc, 5);
    check("t1_cmd_after_rdy", cmd_after_rdy, 8'h00);
    check("t1_cmd_idle", dbg_cmd_o, 8'h00);
    check("t1_addr_hold", dbg_addr_o, 32'h10000004);
    check("t1_data_hold", dbg_data_o, 32'hDEADBEEF);

    // Test 2: ready never comes
    ready_en = 1'b0;
    send_frame(8'h01, 32'h20000008, 32'h11223344);
    wait_resp("t2", 40'hFF00000000);
    check("t2_ncmd", ncmd, 2);
    check("t2_cmd", cap_cmd, 8'h01);
    check("t2_live", live_cyc, TO);
    check("t2_cmd_idle", dbg_cmd_o, 8'h00);
    ready_en = 1'b1;

    // Test 3: partial frame expires on the inter-byte gap
    send_byte(8'h03, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1);
    repeat (GAP + 10) @(negedge clk);
    send_frame(8'h04, 32'h30000000, 32'h55667788);
    wait_resp("t3", 40'h00CAFEF00D);
    check("t3_ncmd", ncmd, 3);
    check("t3_cmd", cap_cmd, 8'h04);
    check("t3_addr", cap_addr, 32'h30000000);
    check("t3_data", cap_data, 32'h55667788);

    // Test 4: framing error drops the partial frame
    send_byte(8'h05, 1'b1);
    send_byte(8'h99, 1'b0);
    send_frame(8'h06, 32'h40000010, 32'h0BADF00D);
    wait_resp("t4", 40'h00CAFEF00D);
    check("t4_ncmd", ncmd, 4);
    check("t4_cmd", cap_cmd, 8'h06);
    check("t4_addr", cap_addr, 32'h40000010);
    check("t4_data", cap_data, 32'h0BADF00D);

    // Test 5: NOP frame is silently discarded
    send_frame(8'h00, 32'h50505050, 32'hA5A5A5A5);
    low_seen = 1'b0;
    cmd_seen = 1'b0;
    for (int i = 0; i < 20 * CPB; i++) begin
      @(negedge clk);
      if (uart_tx_o !== 1'b1) low_seen = 1'b1;
      if (dbg_cmd_o !== 8'h00) cmd_seen = 1'b1;
    end
    check("t5_tx_idle", low_seen, 0);
    check("t5_cmd_nop", cmd_seen, 0);
    check("t5_ncmd", ncmd, 4);
    check("t5_txcount", tx_q.size(), 0);

    // Test 6: reset in the middle of the third response byte
    send_frame(8'h07, 32'h60000020, 32'h12345678);
    n = 0;
    while (tx_q.size() < 2 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("t6_two_bytes", tx_q.size(), 2);
    repeat (3 * CPB) @(negedge clk);
    rstn_i = 1'b0;
    @(posedge clk);
    #1;
    check("t6_rst_tx", uart_tx_o, 1);
    check("t6_rst_cmd", dbg_cmd_o, 8'h00);
    check("t6_rst_addr", dbg_addr_o, 32'h0);
    @(negedge clk);
    rstn_i = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    tx_q.delete();
    send_frame(8'h08, 32'h70000030, 32'h87654321);
    wait_resp("t6", 40'h00CAFEF00D);
    check("t6_ncmd", ncmd, 6);
    check("t6_cmd", cap_cmd, 8'h08);
    check("t6_addr", cap_addr, 32'h70000030);
    check("t6_data", cap_data, 32'h87654321);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
